// File: rtl/star_pkt_buf.sv
// rtl/star_pkt_buf.sv - store-and-forward packet buffer in front of one star_arb src port
// Output valid needs a whole packet buffered, or an oversize packet that fills the array.
module star_pkt_buf #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] src_TDATA,
  input  logic                  src_TVALID,
  output logic                  src_TREADY,
  input  logic                  src_TLAST,
  output logic [DATA_WIDTH-1:0] res_TDATA,
  output logic                  res_TVALID,
  input  logic                  res_TREADY,
  output logic                  res_TLAST,
  output logic [ADDR_WIDTH:0]   level,
  output logic [ADDR_WIDTH:0]   pkt_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, pkt_cnt, level_i;
  logic [ADDR_WIDTH:0] level_nxt, pkt_nxt;
  logic                oversize;
  logic                full, empty, in_beat, out_beat, in_last, out_last;

  assign level_i    = wr_ptr - rd_ptr;
  assign full       = (level_i == FULL_LEVEL);
  assign empty      = (level_i == '0);
  assign src_TREADY = !full && !rst;
  assign res_TVALID = !empty && ((pkt_cnt != '0) || oversize);
  assign {res_TLAST, res_TDATA} = mem[rd_ptr[ADDR_WIDTH-1:0]];

  assign in_beat  = src_TVALID && src_TREADY;
  assign out_beat = res_TVALID && res_TREADY;
  assign in_last  = in_beat && src_TLAST;
  assign out_last = out_beat && res_TLAST;

  assign level     = level_i;
  assign pkt_count = pkt_cnt;

  always_comb begin
    level_nxt = level_i + {{ADDR_WIDTH{1'b0}}, in_beat} - {{ADDR_WIDTH{1'b0}}, out_beat};
    pkt_nxt   = pkt_cnt + {{ADDR_WIDTH{1'b0}}, in_last} - {{ADDR_WIDTH{1'b0}}, out_last};
  end

  always_ff @(posedge clk) begin
    if (in_beat) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {src_TLAST, src_TDATA};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      oversize <= 1'b0;
    end else begin
      if (in_beat)  wr_ptr <= wr_ptr + 1'b1;
      if (out_beat) rd_ptr <= rd_ptr + 1'b1;
      pkt_cnt <= pkt_nxt;
      // A full array with no complete packet would deadlock; let it cut through instead.
      if ((level_nxt == FULL_LEVEL) && (pkt_nxt == '0))
        oversize <= 1'b1;
      else if (out_last)
        oversize <= 1'b0;
    end
  end

endmodule

// File: tb/tb_star_pkt_buf.sv
// tb/tb_star_pkt_buf.sv - directed self-checking bench for star_pkt_buf
module tb_star_pkt_buf;

  localparam int DW = 16;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] src_TDATA;
  logic          src_TVALID;
  logic          src_TREADY;
  logic          src_TLAST;
  logic [DW-1:0] res_TDATA;
  logic          res_TVALID;
  logic          res_TREADY;
  logic          res_TLAST;
  logic [AW:0]   level;
  logic [AW:0]   pkt_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW:0] in_q[$];
  logic [DW:0] exp_q[$];

  star_pkt_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .src_TDATA(src_TDATA), .src_TVALID(src_TVALID), .src_TREADY(src_TREADY), .src_TLAST(src_TLAST),
    .res_TDATA(res_TDATA), .res_TVALID(res_TVALID), .res_TREADY(res_TREADY), .res_TLAST(res_TLAST),
    .level(level), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d, input logic last);
    src_TVALID = 1'b1;
    src_TDATA  = d;
    src_TLAST  = last;
    tick();
    src_TVALID = 1'b0;
    src_TLAST  = 1'b0;
  endtask

  // Drives in_q upstream and checks everything emerging against exp_q, in order.
  task automatic stream(input int budget, input int rdy_mode);
    int cyc = 0;
    logic [DW:0] e;
    while ((in_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
      src_TVALID = (in_q.size() != 0);
      if (in_q.size() != 0) {src_TLAST, src_TDATA} = in_q[0];
      res_TREADY = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) != 1);
      @(negedge clk);
      if (src_TVALID && src_TREADY) void'(in_q.pop_front());
      if (res_TVALID && res_TREADY) begin
        if (exp_q.size() == 0) begin
          check("stream_extra_beat", 32'(res_TDATA), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("stream_data", 32'(res_TDATA), 32'(e[DW-1:0]));
          check("stream_last", 32'(res_TLAST), 32'(e[DW]));
        end
      end
      tick();
      cyc++;
    end
    src_TVALID = 1'b0;
    src_TLAST  = 1'b0;
    res_TREADY = 1'b0;
    check("stream_done", 32'(in_q.size() + exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    src_TDATA = '0; src_TVALID = 1'b0; src_TLAST = 1'b0; res_TREADY = 1'b0;

    // 1: reset
    #1;
    check("rst_res_valid", 32'(res_TVALID), 32'd0);
    check("rst_src_ready", 32'(src_TREADY), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_src_ready", 32'(src_TREADY), 32'd1);
    check("post_rst_res_valid", 32'(res_TVALID), 32'd0);

    // 2: 3-beat packet, store then forward back-to-back
    res_TREADY = 1'b1;
    wr(16'hA0, 1'b0);
    check("a0_valid", 32'(res_TVALID), 32'd0);
    wr(16'hA1, 1'b0);
    check("a1_valid", 32'(res_TVALID), 32'd0);
    wr(16'hA2, 1'b1);
    check("a2_valid", 32'(res_TVALID), 32'd1);
    check("a2_pkt", 32'(pkt_count), 32'd1);
    check("out_a0", 32'(res_TDATA), 32'hA0);
    check("out_a0_last", 32'(res_TLAST), 32'd0);
    tick();
    check("out_a1", 32'(res_TDATA), 32'hA1);
    check("out_a1_last", 32'(res_TLAST), 32'd0);
    tick();
    check("out_a2", 32'(res_TDATA), 32'hA2);
    check("out_a2_last", 32'(res_TLAST), 32'd1);
    check("out_a2_pkt", 32'(pkt_count), 32'd1);
    tick();
    check("a_drained_valid", 32'(res_TVALID), 32'd0);
    check("a_drained_pkt", 32'(pkt_count), 32'd0);
    check("a_drained_level", 32'(level), 32'd0);

    // 3: two 2-beat packets fill the 4-deep array
    res_TREADY = 1'b0;
    wr(16'hB0, 1'b0);
    wr(16'hB1, 1'b1);
    wr(16'hB2, 1'b0);
    wr(16'hB3, 1'b1);
    check("full_src_ready", 32'(src_TREADY), 32'd0);
    check("full_level", 32'(level), 32'd4);
    check("full_pkt", 32'(pkt_count), 32'd2);
    exp_q = '{17'h000B0, 17'h100B1, 17'h000B2, 17'h100B3};
    stream(20, 0);

    // 4: 6-beat packet larger than the array cuts through
    res_TREADY = 1'b1;
    wr(16'h40, 1'b0);
    wr(16'h41, 1'b0);
    wr(16'h42, 1'b0);
    check("ovs_pre_valid", 32'(res_TVALID), 32'd0);
    wr(16'h43, 1'b0);
    check("ovs_level", 32'(level), 32'd4);
    check("ovs_src_ready", 32'(src_TREADY), 32'd0);
    check("ovs_valid", 32'(res_TVALID), 32'd1);
    check("ovs_pkt", 32'(pkt_count), 32'd0);
    check("ovs_first", 32'(res_TDATA), 32'h40);
    in_q  = '{17'h00044, 17'h10045};
    exp_q = '{17'h00040, 17'h00041, 17'h00042, 17'h00043, 17'h00044, 17'h10045};
    stream(30, 0);
    check("ovs_end_level", 32'(level), 32'd0);
    check("ovs_end_pkt", 32'(pkt_count), 32'd0);
    wr(16'h50, 1'b0);
    check("ovs_cleared", 32'(res_TVALID), 32'd0);
    wr(16'h51, 1'b1);
    check("post_ovs_valid", 32'(res_TVALID), 32'd1);
    exp_q = '{17'h00050, 17'h10051};
    stream(20, 0);

    // 5: simultaneous in/out TLAST, then wrap-around stream with stalls
    wr(16'h60, 1'b1);
    check("pre_same_pkt", 32'(pkt_count), 32'd1);
    src_TVALID = 1'b1; src_TDATA = 16'h61; src_TLAST = 1'b1; res_TREADY = 1'b1;
    tick();
    src_TVALID = 1'b0; src_TLAST = 1'b0; res_TREADY = 1'b0;
    check("same_edge_pkt", 32'(pkt_count), 32'd1);
    check("same_edge_level", 32'(level), 32'd1);
    check("same_edge_data", 32'(res_TDATA), 32'h61);
    exp_q.push_back(17'h10061);
    for (int i = 0; i < 12; i++) begin
      in_q.push_back({(i % 3) == 2, 16'(16'h100 + i)});
      exp_q.push_back({(i % 3) == 2, 16'(16'h100 + i)});
    end
    stream(200, 1);
    check("wrap_level", 32'(level), 32'd0);
    check("wrap_pkt", 32'(pkt_count), 32'd0);

    // 6: asynchronous reset mid-packet
    wr(16'h70, 1'b1);
    wr(16'h71, 1'b0);
    check("pre_rst_valid", 32'(res_TVALID), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_res_valid", 32'(res_TVALID), 32'd0);
    check("arst_src_ready", 32'(src_TREADY), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_pkt", 32'(pkt_count), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rerst_src_ready", 32'(src_TREADY), 32'd1);
    check("rerst_valid", 32'(res_TVALID), 32'd0);
    in_q  = '{17'h00080, 17'h00081, 17'h10082};
    exp_q = '{17'h00080, 17'h00081, 17'h10082};
    stream(30, 0);
    check("final_level", 32'(level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
